// File: rtl/seq_detect_pkg.sv
// Shared constants and elaboration helpers for the parametrised Moore sequence detector.
package seq_detect_pkg;

    localparam logic OVL_OFF = 1'b0;
    localparam logic OVL_ON  = 1'b1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Width needed to hold progress values 0..pat_len.
    function automatic int unsigned state_width(input int unsigned pat_len);
        return clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/seq_next_state.sv
// Prefix-function next-state logic: longest pattern prefix that ends the
// matched prefix extended by the incoming bit.
module seq_next_state
    import seq_detect_pkg::*;
#(
    parameter int unsigned PAT_LEN = 4,
    parameter int unsigned SW      = state_width(PAT_LEN)
) (
    input  logic [SW-1:0]      state_i,
    input  logic               b_i,
    input  logic [PAT_LEN-1:0] pattern_i,
    input  logic               overlap_i,
    output logic [SW-1:0]      next_state_c
);

    localparam int unsigned HW = PAT_LEN + 1;

    logic [SW-1:0] start;
    logic [HW-1:0] pat_ext;
    logic [HW-1:0] hist;
    logic [HW-1:0] mask;
    logic [HW-1:0] want;

    always_comb begin
        start        = state_i;
        pat_ext      = HW'(pattern_i);
        hist         = '0;
        mask         = '0;
        want         = '0;
        next_state_c = '0;

        // Non-overlap mode consumes a completed match before the new bit.
        case (overlap_i)
            OVL_OFF: if (state_i == SW'(PAT_LEN)) start = '0;
            OVL_ON:  start = state_i;
        endcase

        // Matched prefix (first `start` pattern bits) followed by the new bit, LSB = newest.
        hist = ((pat_ext >> (SW'(PAT_LEN) - start)) << 1) | HW'(b_i);

        for (int unsigned l = 1; l <= PAT_LEN; l++) begin
            mask = (HW'(1) << l) - HW'(1);
            want = pat_ext >> (PAT_LEN - l);
            if ((l <= 32'(start) + 32'd1) && ((hist & mask) == want)) begin
                next_state_c = SW'(l);
            end
        end
    end

endmodule

// File: rtl/seq_detect_moore_param.sv
// Run-time programmable Moore serial sequence detector with qualifier,
// overlap control and a saturating match counter.
module seq_detect_moore_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] RST_PAT = PAT_LEN'(4'b1011),
    parameter int unsigned        CNT_W   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              x,
    input  logic                              x_valid,
    input  logic                              load,
    input  logic [PAT_LEN-1:0]                pattern_in,
    input  logic                              overlap,
    input  logic                              clear,
    output logic                              Z,
    output logic [state_width(PAT_LEN)-1:0]   state_o,
    output logic [CNT_W-1:0]                  match_cnt,
    output logic                              cnt_sat
);

    localparam int unsigned SW = state_width(PAT_LEN);

    logic [SW-1:0]      state_q, state_d, step_c;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               z_q, z_d;

    seq_next_state #(
        .PAT_LEN (PAT_LEN),
        .SW      (SW)
    ) u_next (
        .state_i      (state_q),
        .b_i          (x),
        .pattern_i    (pat_q),
        .overlap_i    (overlap),
        .next_state_c (step_c)
    );

    // Load restarts detection and masks the bit; clear overrides any increment.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;

        if (load) begin
            pat_d   = pattern_in;
            state_d = '0;
        end else if (x_valid) begin
            state_d = step_c;
            if ((step_c == SW'(PAT_LEN)) && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (clear) begin
            cnt_d = '0;
        end

        z_d = (state_d == SW'(PAT_LEN));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            pat_q   <= RST_PAT;
            cnt_q   <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
        end
    end

    assign Z         = z_q;
    assign state_o   = state_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = &cnt_q;

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Scoreboard bench for seq_detect_moore_param: directed scenarios plus
// randomized traffic against a bit-history reference model.
module tb_seq_detect_moore_param;

    localparam int PAT_LEN = 4;
    localparam int CNT_W   = 8;
    localparam int SW      = 3;
    localparam int CNT_MAX = 255;

    logic               clk = 1'b0;
    logic               rst;
    logic               x;
    logic               x_valid;
    logic               load;
    logic [PAT_LEN-1:0] pattern_in;
    logic               overlap;
    logic               clear;
    logic               Z;
    logic [SW-1:0]      state_o;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;

    typedef struct {
        int z;
        int st;
        int cnt;
        int sat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: raw history of valid bits since the last restart point.
    logic [PAT_LEN-1:0] m_pat;
    bit                 m_hist[$];
    int                 m_st;
    int                 m_cnt;

    seq_detect_moore_param #(
        .PAT_LEN (PAT_LEN),
        .RST_PAT (4'b1011),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .x_valid    (x_valid),
        .load       (load),
        .pattern_in (pattern_in),
        .overlap    (overlap),
        .clear      (clear),
        .Z          (Z),
        .state_o    (state_o),
        .match_cnt  (match_cnt),
        .cnt_sat    (cnt_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_pat = 4'b1011;
        m_hist.delete();
        m_st  = 0;
        m_cnt = 0;
    endtask

    // Progress = longest tail of the history that equals the head of the pattern.
    task automatic model_edge(input logic xb, input logic v, input logic ld,
                              input logic [PAT_LEN-1:0] pin, input logic ovl, input logic clr);
        bit ok;
        if (ld) begin
            m_pat = pin;
            m_hist.delete();
            m_st  = 0;
        end else if (v) begin
            if (!ovl && m_st == PAT_LEN) m_hist.delete();
            m_hist.push_back(xb);
            if (m_hist.size() > PAT_LEN) void'(m_hist.pop_front());
            m_st = 0;
            for (int l = 1; l <= m_hist.size(); l++) begin
                ok = 1'b1;
                for (int i = 0; i < l; i++) begin
                    if (m_hist[m_hist.size() - l + i] != m_pat[PAT_LEN - 1 - i]) ok = 1'b0;
                end
                if (ok) m_st = l;
            end
            if (m_st == PAT_LEN && m_cnt < CNT_MAX) m_cnt++;
        end
        if (clr) m_cnt = 0;
    endtask

    task automatic drive(input logic xb, input logic v, input logic ld,
                         input logic [PAT_LEN-1:0] pin, input logic ovl, input logic clr);
        exp_t e;
        @(negedge clk);
        x          = xb;
        x_valid    = v;
        load       = ld;
        pattern_in = pin;
        overlap    = ovl;
        clear      = clr;
        model_edge(xb, v, ld, pin, ovl, clr);
        e.z   = (m_st == PAT_LEN) ? 1 : 0;
        e.st  = m_st;
        e.cnt = m_cnt;
        e.sat = (m_cnt == CNT_MAX) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    // Bits are left-aligned: bits[15] goes first.
    task automatic send_bits(input logic [15:0] bits, input int n, input logic ovl);
        logic [15:0] sh;
        sh = bits;
        for (int i = 0; i < n; i++) begin
            drive(sh[15], 1'b1, 1'b0, 4'b0000, ovl, 1'b0);
            sh = sh << 1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_Z"},     int'(Z),         0);
        check({tag, "_state"}, int'(state_o),   0);
        check({tag, "_cnt"},   int'(match_cnt), 0);
        check({tag, "_sat"},   int'(cnt_sat),   0);
    endtask

    task automatic quiet_inputs();
        x_valid = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
    endtask

    // Reset asserted between edges must take effect without a clock.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        quiet_inputs();
        rst = 1'b1;
        #1;
        check_reset_values(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("Z",         int'(Z),         e.z);
            check("state_o",   int'(state_o),   e.st);
            check("match_cnt", int'(match_cnt), e.cnt);
            check("cnt_sat",   int'(cnt_sat),   e.sat);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic               r_x, r_v, r_ld, r_ovl, r_clr;
        logic [PAT_LEN-1:0] r_pin;

        rst        = 1'b0;
        x          = 1'b0;
        overlap    = 1'b1;
        pattern_in = '0;
        quiet_inputs();
        #3;
        rst = 1'b1;
        #1;
        check_reset_values("por");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Overlap on, 1011011: matches after bits 4 and 7.
        send_bits(16'b1011011_000000000, 7, 1'b1);
        settle();
        check("ovl_on_cnt", int'(match_cnt), 2);
        check("ovl_on_Z",   int'(Z),         1);

        // Overlap off, same stream after a clear: only one match, ends in state 1.
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        send_bits(16'b1011011_000000000, 7, 1'b0);
        settle();
        check("ovl_off_cnt",   int'(match_cnt), 1);
        check("ovl_off_state", int'(state_o),   1);

        // Load+clear together, then 1,0,gap,1,1,gap: Z holds through the gap.
        drive(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1);
        send_bits(16'b10_00000000000000, 2, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'($urandom_range(1)), 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        send_bits(16'b11_00000000000000, 2, 1'b1);
        for (int i = 0; i < 2; i++) drive(1'($urandom_range(1)), 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        settle();
        check("gap_cnt", int'(match_cnt), 1);
        check("gap_Z",   int'(Z),         1);

        // Load 1111 with a valid 1 on the load edge (ignored), then five 1s.
        drive(1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1);
        send_bits(16'b11111_00000000000, 5, 1'b1);
        settle();
        check("load_cnt", int'(match_cnt), 2);

        // Saturate the counter, then clear on an edge that also matches.
        for (int i = 0; i < 260; i++) drive(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        settle();
        check("sat_cnt",  int'(match_cnt), CNT_MAX);
        check("sat_flag", int'(cnt_sat),   1);
        drive(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
        settle();
        check("clr_win_cnt", int'(match_cnt), 0);
        check("clr_win_Z",   int'(Z),         1);

        // Mid-sequence reset restores the 1011 pattern.
        send_bits(16'b10_00000000000000, 2, 1'b1);
        async_reset("mid");
        send_bits(16'b1011_000000000000, 4, 1'b1);
        settle();
        check("post_rst_cnt", int'(match_cnt), 1);

        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) begin
                async_reset("rnd");
                continue;
            end
            r_x   = 1'($urandom_range(1));
            r_v   = ($urandom_range(99) < 75) ? 1'b1 : 1'b0;
            r_ld  = ($urandom_range(99) < 2)  ? 1'b1 : 1'b0;
            r_ovl = ($urandom_range(99) < 60) ? 1'b1 : 1'b0;
            r_clr = ($urandom_range(99) < 1)  ? 1'b1 : 1'b0;
            r_pin = 4'($urandom_range(15));
            drive(r_x, r_v, r_ld, r_pin, r_ovl, r_clr);
        end

        settle();
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
